// File: rtl/uart_print_fifo.sv
// ---------------------------------------------------------------------------
// uart_print_fifo
//
// Capture buffer for console characters that the CPU pushes into the UART
// transmitter. Each tf_push_i strobe offers one byte. Accepted bytes land in a
// circular register array, and a host-side reader drains them through a
// valid/ready pop interface. Bytes that arrive while the buffer is full and no
// pop frees a slot are dropped. The drops are counted in a saturating
// counter, so software can detect lost output.
//
// Optional build feature (macro UART_PRINT_LINE_EN):
//   defined     - accepted newline bytes (0x0A) are counted, and each one
//                 raises a one-cycle line_done_o pulse.
//   not defined - line_cnt_o and line_done_o are tied to zero, and no line
//                 logic is built.
//
// Parameters:
//   DEPTH_LOG2   buffer depth is 2**DEPTH_LOG2 bytes (legal range 2..10)
//
// Ports:
//   clk_i         system clock (same domain as the UART)
//   rst_i         synchronous active-high reset
//   print_data_i  character byte, sampled while tf_push_i is high
//   tf_push_i     one-cycle write strobe, one character per high cycle
//   clr_i         synchronous flush; has priority over push and pop
//   rd_ready_i    reader accepts the head entry this cycle
//   rd_valid_o    head entry present
//   rd_data_o     head entry (asynchronous read of the array)
//   count_o       number of stored entries
//   full_o        buffer holds 2**DEPTH_LOG2 entries
//   empty_o       buffer holds no entries
//   ovf_cnt_o     saturating count of dropped characters
//   line_cnt_o    saturating count of accepted newlines (line build only)
//   line_done_o   pulse in the cycle after a newline is accepted (line build)
// ---------------------------------------------------------------------------
module uart_print_fifo #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            print_data_i,
    input  logic                  tf_push_i,
    input  logic                  clr_i,
    input  logic                  rd_ready_i,
    output logic                  rd_valid_o,
    output logic [7:0]            rd_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [15:0]           ovf_cnt_o,
    output logic [15:0]           line_cnt_o,
    output logic                  line_done_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Occupancy value that means "full": only the top bit of cnt set.
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_r;
    logic [DEPTH_LOG2-1:0] rp_r;
    logic [DEPTH_LOG2:0]   cnt_r;
    logic [15:0]           ovf_cnt_r;

    logic                  full_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [DEPTH_LOG2:0]   cnt_next_s;

    // Handshake decode. A pop in the same cycle frees a slot, so a push into
    // a full buffer is still accepted when the reader drains the head entry.
    always_comb begin
        full_s  = (cnt_r == FULL_CNT);
        valid_s = (cnt_r != {(DEPTH_LOG2+1){1'b0}});
        pop_s   = rd_ready_i & valid_s;
        push_s  = tf_push_i & (~full_s | pop_s);
        drop_s  = tf_push_i & full_s & ~pop_s;
    end

    // Occupancy next-state: +1 on push, -1 on pop, unchanged for both or neither.
    always_comb begin
        cnt_next_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
            2'b01:   cnt_next_s = cnt_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Pointer, occupancy and drop-counter state. Reset and flush share the
    // same effect on this state.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wp_r      <= {DEPTH_LOG2{1'b0}};
            rp_r      <= {DEPTH_LOG2{1'b0}};
            cnt_r     <= {(DEPTH_LOG2+1){1'b0}};
            ovf_cnt_r <= 16'h0000;
        end else begin
            if (push_s) begin
                wp_r <= wp_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rp_r <= rp_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            cnt_r <= cnt_next_s;
            if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 16'h0001;
            end
        end
    end

    // Storage array. It is never reset. A push that coincides with reset or a
    // flush is discarded.
    always_ff @(posedge clk_i) begin
        if (push_s && !clr_i && !rst_i) begin
            mem_r[wp_r] <= print_data_i;
        end
    end

    assign rd_valid_o = valid_s;
    assign rd_data_o  = mem_r[rp_r];
    assign count_o    = cnt_r;
    assign full_o     = full_s;
    assign empty_o    = ~valid_s;
    assign ovf_cnt_o  = ovf_cnt_r;

`ifdef UART_PRINT_LINE_EN
    logic [15:0] line_cnt_r;
    logic        line_done_r;
    logic        newline_s;

    // A newline only counts when its push is actually accepted.
    always_comb begin
        if (push_s && (print_data_i == 8'h0A)) begin
            newline_s = 1'b1;
        end else begin
            newline_s = 1'b0;
        end
    end

    // Newline counter and completion pulse. A flush discards the concurrent
    // push, so it also suppresses the pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            line_cnt_r  <= 16'h0000;
            line_done_r <= 1'b0;
        end else begin
            line_done_r <= newline_s;
            if (newline_s && (line_cnt_r != 16'hFFFF)) begin
                line_cnt_r <= line_cnt_r + 16'h0001;
            end
        end
    end

    assign line_cnt_o  = line_cnt_r;
    assign line_done_o = line_done_r;
`else
    assign line_cnt_o  = 16'h0000;
    assign line_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_print_fifo.sv
module tb_uart_print_fifo;

    localparam int DL2 = 2;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic [7:0]     print_data_i = 8'h00;
    logic           tf_push_i = 1'b0;
    logic           clr_i = 1'b0;
    logic           rd_ready_i = 1'b0;
    logic           rd_valid_o;
    logic [7:0]     rd_data_o;
    logic [DL2:0]   count_o;
    logic           full_o;
    logic           empty_o;
    logic [15:0]    ovf_cnt_o;
    logic [15:0]    line_cnt_o;
    logic           line_done_o;

    int checks = 0;
    int failures = 0;

    uart_print_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .print_data_i(print_data_i),
        .tf_push_i(tf_push_i), .clr_i(clr_i), .rd_ready_i(rd_ready_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .count_o(count_o),
        .full_o(full_o), .empty_o(empty_o), .ovf_cnt_o(ovf_cnt_o),
        .line_cnt_o(line_cnt_o), .line_done_o(line_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge, then settle 1 ns so outputs reflect that edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        checks++; if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", rd_valid_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0d exp=1", empty_o); end
        checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%0d exp=0", full_o); end
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (ovf_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", ovf_cnt_o); end
        checks++; if (line_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_line_cnt got=%0d exp=0", line_cnt_o); end
        checks++; if (line_done_o !== 1'b0) begin failures++; $display("FAIL reset_line_done got=%0d exp=0", line_done_o); end
    endtask

    task automatic test_basic();
        tf_push_i = 1'b1; print_data_i = 8'h48;
        tick();
        checks++; if (rd_valid_o !== 1'b1) begin failures++; $display("FAIL basic_latency_valid got=%0d exp=1", rd_valid_o); end
        checks++; if (rd_data_o !== 8'h48) begin failures++; $display("FAIL basic_latency_data got=%h exp=48", rd_data_o); end
        print_data_i = 8'h69;
        tick();
        tf_push_i = 1'b0;
        checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", count_o); end
        checks++; if (rd_data_o !== 8'h48) begin failures++; $display("FAIL basic_head got=%h exp=48", rd_data_o); end
        rd_ready_i = 1'b1;
        tick();
        checks++; if (rd_data_o !== 8'h69) begin failures++; $display("FAIL basic_second got=%h exp=69", rd_data_o); end
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", count_o); end
        tick();
        rd_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL basic_empty got=%0d exp=1", empty_o); end
        checks++; if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL basic_valid0 got=%0d exp=0", rd_valid_o); end
    endtask

    task automatic test_overflow();
        tf_push_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            print_data_i = 8'(i);
            tick();
        end
        tf_push_i = 1'b0;
        checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL ovf_full got=%0d exp=1", full_o); end
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count_o); end
        checks++; if (ovf_cnt_o !== 16'd2) begin failures++; $display("FAIL ovf_cnt got=%0d exp=2", ovf_cnt_o); end
    endtask

    // Full buffer: simultaneous push and pop, then drain and check order.
    task automatic test_full_push_pop();
        logic [7:0] exp_q [5];
        exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h04; exp_q[4] = 8'hAA;
        checks++; if (rd_data_o !== exp_q[0]) begin failures++; $display("FAIL fullpp_head got=%h exp=%h", rd_data_o, exp_q[0]); end
        tf_push_i = 1'b1; print_data_i = 8'hAA; rd_ready_i = 1'b1;
        tick();
        tf_push_i = 1'b0;
        checks++; if (ovf_cnt_o !== 16'd2) begin failures++; $display("FAIL fullpp_ovf got=%0d exp=2", ovf_cnt_o); end
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fullpp_count got=%0d exp=4", count_o); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (rd_data_o !== exp_q[i]) begin failures++; $display("FAIL fullpp_read%0d got=%h exp=%h", i, rd_data_o, exp_q[i]); end
            tick();
        end
        rd_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL fullpp_empty got=%0d exp=1", empty_o); end
        checks++; if (ovf_cnt_o !== 16'd2) begin failures++; $display("FAIL fullpp_ovf_end got=%0d exp=2", ovf_cnt_o); end
    endtask

    task automatic test_empty_push_pop();
        tf_push_i = 1'b1; print_data_i = 8'h55; rd_ready_i = 1'b1;
        tick();
        tf_push_i = 1'b0; rd_ready_i = 1'b0;
        checks++; if (rd_valid_o !== 1'b1) begin failures++; $display("FAIL emptypp_valid got=%0d exp=1", rd_valid_o); end
        checks++; if (rd_data_o !== 8'h55) begin failures++; $display("FAIL emptypp_data got=%h exp=55", rd_data_o); end
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL emptypp_count got=%0d exp=1", count_o); end
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL emptypp_drain got=%0d exp=1", empty_o); end
    endtask

    task automatic test_clear();
        tf_push_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            print_data_i = 8'h30 + 8'(i);
            tick();
        end
        checks++; if (count_o !== 3'd3) begin failures++; $display("FAIL clr_pre_count got=%0d exp=3", count_o); end
        print_data_i = 8'h77; clr_i = 1'b1;
        tick();
        clr_i = 1'b0; tf_push_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", count_o); end
        checks++; if (ovf_cnt_o !== 16'd0) begin failures++; $display("FAIL clr_ovf got=%0d exp=0", ovf_cnt_o); end
        checks++; if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL clr_valid got=%0d exp=0", rd_valid_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL clr_empty got=%0d exp=1", empty_o); end
    endtask

    task automatic test_lines();
        logic [7:0] str [4];
        logic       exp_done;
        logic [15:0] exp_lines;
        str[0] = 8'h61; str[1] = 8'h0A; str[2] = 8'h62; str[3] = 8'h0A;
        exp_lines = 16'd0;
        tf_push_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            print_data_i = str[i];
            tick();
`ifdef UART_PRINT_LINE_EN
            exp_done = (str[i] == 8'h0A);
            if (exp_done) exp_lines = exp_lines + 16'd1;
`else
            exp_done = 1'b0;
`endif
            checks++; if (line_done_o !== exp_done) begin failures++; $display("FAIL line_done%0d got=%0d exp=%0d", i, line_done_o, exp_done); end
        end
        tf_push_i = 1'b0;
        tick();
        checks++; if (line_done_o !== 1'b0) begin failures++; $display("FAIL line_done_idle got=%0d exp=0", line_done_o); end
        checks++; if (line_cnt_o !== exp_lines) begin failures++; $display("FAIL line_cnt got=%0d exp=%0d", line_cnt_o, exp_lines); end
        // Buffer now full: a dropped newline must not count.
        tf_push_i = 1'b1; print_data_i = 8'h0A;
        tick();
        tf_push_i = 1'b0;
        checks++; if (ovf_cnt_o !== 16'd1) begin failures++; $display("FAIL line_drop_ovf got=%0d exp=1", ovf_cnt_o); end
        checks++; if (line_done_o !== 1'b0) begin failures++; $display("FAIL line_drop_done got=%0d exp=0", line_done_o); end
        checks++; if (line_cnt_o !== exp_lines) begin failures++; $display("FAIL line_drop_cnt got=%0d exp=%0d", line_cnt_o, exp_lines); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        checks++; if (line_cnt_o !== 16'd0) begin failures++; $display("FAIL line_clr got=%0d exp=0", line_cnt_o); end
    endtask

    task automatic test_back_to_back();
        tf_push_i = 1'b1; rd_ready_i = 1'b1; print_data_i = 8'h10;
        tick();
        for (int i = 1; i <= 5; i++) begin
            checks++; if (rd_data_o !== 8'h10 + 8'(i - 1)) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, rd_data_o, 8'h10 + 8'(i - 1)); end
            checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=1", i, count_o); end
            print_data_i = 8'h10 + 8'(i);
            tick();
        end
        tf_push_i = 1'b0;
        checks++; if (rd_data_o !== 8'h15) begin failures++; $display("FAIL b2b_last got=%h exp=15", rd_data_o); end
        tick();
        rd_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%0d exp=1", empty_o); end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_clear();
        test_lines();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
